// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for a PS/2 line;
// emits a one-cycle strobe on each falling edge of the filtered level.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          meta_q, sync_q, filt_q, fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      fall_q <= 1'b0;
      // cnt_q counts consecutive samples that disagree with the filtered level
      if (sync_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        cnt_q  <= '0;
        filt_q <= sync_q;
        fall_q <= filt_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 receiver: deframes 11-bit frames, checks parity/stop, folds E0/F0
// prefixes into flags and tracks the currently held make code.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_brk,
  output logic [7:0] keycode,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic          fall, clk_filt;
  logic          data_meta_q, data_sync_q;
  ps2_state_e    state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;
  logic [TW-1:0] tmo_q;
  logic          ext_pend_q, brk_pend_q;
  logic          code_valid_q, code_ext_q, code_brk_q, frame_err_q;
  logic [7:0]    code_q, keycode_q;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk),
    .filt_o (clk_filt),
    .fall_o (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      tmo_q        <= '0;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      code_ext_q   <= 1'b0;
      code_brk_q   <= 1'b0;
      keycode_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        // tmo_q holds the number of cycles elapsed since the most recent fall
        tmo_q <= TW'(1);
        unique case (state_q)
          IDLE: begin
            if (!data_sync_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          DATA: begin
            shift_q   <= {data_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= data_sync_q;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (data_sync_q && (^{shift_q, parity_q})) begin
              if (shift_q == PS2_EXT) begin
                ext_pend_q <= 1'b1;
              end else if (shift_q == PS2_BRK) begin
                brk_pend_q <= 1'b1;
              end else begin
                code_valid_q <= 1'b1;
                code_q       <= shift_q;
                code_ext_q   <= ext_pend_q;
                code_brk_q   <= brk_pend_q;
                ext_pend_q   <= 1'b0;
                brk_pend_q   <= 1'b0;
                if (!brk_pend_q) keycode_q <= shift_q;
                else if (shift_q == keycode_q) keycode_q <= 8'h00;
              end
            end else begin
              frame_err_q <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end
          end
        endcase
      end else if (state_q != IDLE) begin
        if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q     <= IDLE;
          frame_err_q <= 1'b1;
          ext_pend_q  <= 1'b0;
          brk_pend_q  <= 1'b0;
          tmo_q       <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign code_valid = code_valid_q;
  assign code       = code_q;
  assign code_ext   = code_ext_q;
  assign code_brk   = code_brk_q;
  assign keycode    = keycode_q;
  assign frame_err  = frame_err_q;

  logic unused_filt;
  assign unused_filt = clk_filt;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-bangs PS/2 frames and checks
// decoded codes, flags, held keycode, error pulses and latencies.
module tb_ps2_scancode_rx;
  import ps2_pkg::*;

  localparam int FLT = 8;
  localparam int TMO = 300;
  localparam int HP  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_valid, code_ext, code_brk, frame_err;
  logic [7:0] code, keycode;

  int cyc = 0, drop_cyc = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0, cv_cyc = 0, fe_cyc = 0;
  int total = 0, bad = 0;
  int cv0, fe0;

  ps2_scancode_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_valid (code_valid),
    .code       (code),
    .code_ext   (code_ext),
    .code_brk   (code_brk),
    .keycode    (keycode),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin cv_cnt++; cv_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (code_valid && frame_err) both_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HP);
      ps2_clk  = 1'b0;
      drop_cyc = cyc;
      wait_cyc(HP);
      ps2_clk  = 1'b1;
    end
    wait_cyc(HP);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_bits(mk(b, 1'b0), 11);
    $display("frame %02h: cv=%0d fe=%0d code=%02h ext=%0b brk=%0b keycode=%02h",
             b, cv_cnt, fe_cnt, code, code_ext, code_brk, keycode);
  endtask

  initial begin
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(2);
    check("rst_code", 32'(code), 32'h00);
    check("rst_keycode", 32'(keycode), 32'h00);
    check("rst_flags", 32'({code_valid, code_ext, code_brk, frame_err}), 32'h0);

    // single make of 0x75, with stop-bit latency
    send(KEY_UP);
    check("up_cnt", cv_cnt, 1);
    check("up_code", 32'(code), 32'h75);
    check("up_ext_brk", 32'({code_ext, code_brk}), 32'h0);
    check("up_keycode", 32'(keycode), 32'h75);
    check("up_latency", cv_cyc - drop_cyc, 2 + FLT + 1);
    check("up_no_err", fe_cnt, 0);

    // extended make then extended break
    cv0 = cv_cnt;
    send(PS2_EXT);
    send(KEY_UP);
    check("ext_make_code", 32'({code, code_ext, code_brk}), 32'({8'h75, 2'b10}));
    check("ext_make_key", 32'(keycode), 32'h75);
    send(PS2_EXT);
    send(PS2_BRK);
    send(KEY_UP);
    check("ext_brk_code", 32'({code, code_ext, code_brk}), 32'({8'h75, 2'b11}));
    check("ext_brk_key", 32'(keycode), 32'h00);
    check("ext_pulses", cv_cnt - cv0, 2);

    // make left, make right, break left
    send(KEY_LEFT);
    check("left_key", 32'(keycode), 32'h6B);
    send(KEY_RIGHT);
    check("right_key", 32'(keycode), 32'h74);
    send(PS2_BRK);
    send(KEY_LEFT);
    check("brk_left_code", 32'({code, code_ext, code_brk}), 32'({8'h6B, 2'b01}));
    check("brk_left_key", 32'(keycode), 32'h74);

    // parity error then a good frame
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_bits(mk(KEY_DOWN, 1'b1), 11);
    $display("frame 72 bad parity: cv=%0d fe=%0d keycode=%02h", cv_cnt, fe_cnt, keycode);
    check("par_err", fe_cnt - fe0, 1);
    check("par_no_cv", cv_cnt - cv0, 0);
    check("par_key", 32'(keycode), 32'h74);
    send(KEY_DOWN);
    check("down_code", 32'(code), 32'h72);
    check("down_key", 32'(keycode), 32'h72);

    // partial frame followed by timeout
    fe0 = fe_cnt;
    send_bits(mk(KEY_SPACE, 1'b0), 5);
    wait_cyc(TMO + 40);
    $display("partial frame: fe=%0d fe_cyc-drop=%0d", fe_cnt, fe_cyc - drop_cyc);
    check("tmo_err", fe_cnt - fe0, 1);
    check("tmo_latency", fe_cyc - drop_cyc, 2 + FLT + TMO);
    send(KEY_SPACE);
    check("space_code", 32'({code, code_ext, code_brk}), 32'({8'h29, 2'b00}));

    // short glitch on ps2_clk while idle
    cv0 = cv_cnt; fe0 = fe_cnt;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    $display("glitch: cv=%0d fe=%0d", cv_cnt, fe_cnt);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_cv", cv_cnt - cv0, 0);

    // reset in the middle of a frame
    send_bits(mk(KEY_ESC, 1'b0), 4);
    rst = 1'b0;
    wait_cyc(1);
    rst = 1'b1;
    check("mid_rst_out", 32'({code, keycode, code_valid, code_ext, code_brk, frame_err}), 32'h0);
    wait_cyc(40);
    check("mid_rst_fe", fe_cnt - fe0, 0);
    send(KEY_ESC);
    check("esc_code", 32'({code, code_ext, code_brk}), 32'({8'h76, 2'b00}));
    check("esc_key", 32'(keycode), 32'h76);
    check("esc_cv", cv_cnt - cv0, 1);

    check("never_both", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
- Upstream front end for the keyboard decoder: turns raw PS/2 clock/data lines into validated scan-code bytes.
- Synchronises and filters the PS/2 lines, deframes 11-bit frames and checks parity and stop bit.
- Folds E0 (extended) and F0 (break) prefixes into flags on the following code.
- Keeps a held `keycode` byte, the current make code, which is what the arrow-key decoder consumes.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before filtered ps2_clk changes level.
- TIMEOUT_CYC, 50000: clk cycles without a filtered ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- ps2_clk  in  1  raw keyboard clock, asynchronous.
- ps2_data  in  1  raw keyboard data, asynchronous.
- code_valid  out  1  one-cycle pulse: `code`, `code_ext` and `code_brk` are valid.
- code  out  8  last non-prefix scan byte.
- code_ext  out  1  `code` was preceded by E0.
- code_brk  out  1  `code` was preceded by F0 (key release).
- keycode  out  8  held make code; 8'h00 when no key is held.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0; FSM to IDLE; bit counter, shift register, timeout counter and prefix flags cleared.
  - Synchroniser and filter state preset to 1 (line idle).
  - Reset mid-frame discards the partial frame with no pulses.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-FF synchroniser.
  - Filtered clock toggles only after FILTER_LEN equal samples; a glitch shorter than that is ignored.
  - A falling edge of the filtered clock (fall) is a 1-cycle strobe; sampled data is the synchronised ps2_data in the fall cycle.
- FSM (state changes in the cycle after fall):
  - IDLE: on fall, data=0 goes to DATA with bit count 0; data=1 is a bad start, so pulse frame_err and stay IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: store the bit; go to STOP.
  - STOP: the frame is good if data=1 and XOR(8 data bits, parity)=1 (odd parity). Always return to IDLE.
- Timeout:
  - The counter clears on every fall and counts while not IDLE.
  - At TIMEOUT_CYC: go to IDLE, pulse frame_err, clear prefix flags.
- Byte handling on a good frame (acted on the cycle after the STOP fall):
  - 8'hE0: set ext_pend; no code_valid.
  - 8'hF0: set brk_pend; no code_valid.
  - Any other byte B:
    - Pulse code_valid with code=B, code_ext=ext_pend, code_brk=brk_pend; clear both pends.
    - keycode: make (brk_pend=0) sets keycode=B; break (brk_pend=1) with B==keycode clears keycode to 8'h00; otherwise keycode is unchanged.
- Bad parity or stop: pulse frame_err, discard the byte, clear pends; keycode unchanged.
- code, code_ext and code_brk hold their values between pulses.
- frame_err and code_valid are never asserted in the same cycle.
- Latency: code_valid asserts exactly 1 clk after the fall of the stop bit.
- Back-to-back frames with no idle gap are accepted: IDLE accepts a start bit on the very next fall.

Decomposition:
- Package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Arrow codes 75/72/6B/74, SPACE 29, ESC 76.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
- One sub-module, ps2_line_filter: 2-FF sync, FILTER_LEN glitch filter and fall-strobe generation. Instantiated for ps2_clk; ps2_data uses only its synchroniser output.

Test Plan:
- Frame 0x75 (odd parity bit 0, stop 1) at 12.5 kHz → one code_valid pulse with code=75, ext=0, brk=0; keycode=75; frame_err never asserts.
- Frames E0, 75, then E0, F0, 75 → first code_valid: code=75, ext=1, brk=0, keycode=75. Second: code=75, ext=1, brk=1, keycode=00. Exactly two code_valid pulses in total.
- Make 6B, make 74, break 6B → keycode goes 6B, then 74, then stays 74. The break pulse has code=6B, brk=1.
- Frame 0x72 with parity flipped → one frame_err pulse, no code_valid, keycode unchanged. A following good 0x72 gives code_valid and keycode=72.
- Five bits of a frame, then ps2_clk held high → frame_err exactly TIMEOUT_CYC cycles after the last fall. A following good 0x29 decodes correctly.
- 3-cycle low glitch on ps2_clk during idle → no state change. rst=0 asserted mid-frame for one cycle → all outputs 0, then a clean frame 0x76 decodes with code=76.
